// File: rtl/ysyx_22040210_div_iter.sv
// rtl/ysyx_22040210_div_iter.sv - iterative restoring divider, signed/unsigned, optional 32-bit word mode
// Optional feature: define YSYX_22040210_DIV_EARLY_OUT_EN to skip the CALC phase when |dividend| < |divisor|.
// One quotient bit retires per CALC cycle; divide-by-zero and signed overflow always bypass CALC.
module ysyx_22040210_div_iter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             signed_i,
   input  logic             word_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             busy_o
);

   // Word mode only exists for 64-bit builds; SH is the shift that isolates the low 32 bits.
   localparam int SH = (WIDTH == 64) ? 32 : 0;
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_FULL = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MIN_WORD = $signed(MIN_FULL) >>> SH;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic [CW-1:0]    cnt_q;
   logic             negq_q, negr_q, word_q;
   logic [WIDTH-1:0] quotient_q, remainder_q;

   function automatic logic [WIDTH-1:0] sext32(input logic [WIDTH-1:0] x);
      sext32 = $signed(x << SH) >>> SH;
   endfunction

   function automatic logic [WIDTH-1:0] zext32(input logic [WIDTH-1:0] x);
      zext32 = (x << SH) >> SH;
   endfunction

   logic             word_act, accept, a_neg, b_neg, div_zero, ovf, early, shortcut;
   logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag, short_q, short_r;

   assign word_act = (WIDTH == 64) && word_i;
   assign in_ready = (state_q == IDLE) & ~flush & ~rst;
   assign accept   = in_valid & in_ready;
   assign out_valid = (state_q == DONE) & ~rst;
   assign busy_o    = (state_q != IDLE) & ~rst;
   assign quotient_o  = quotient_q;
   assign remainder_o = remainder_q;

   // Operand conditioning: word extraction, sign detection, magnitudes and bypass cases.
   always_comb begin
      a_ext    = dividend_i;
      b_ext    = divisor_i;
      if (word_act) begin
         a_ext = signed_i ? sext32(dividend_i) : zext32(dividend_i);
         b_ext = signed_i ? sext32(divisor_i)  : zext32(divisor_i);
      end
      a_neg    = signed_i & a_ext[WIDTH-1];
      b_neg    = signed_i & b_ext[WIDTH-1];
      a_mag    = a_neg ? ('0 - a_ext) : a_ext;
      b_mag    = b_neg ? ('0 - b_ext) : b_ext;
      div_zero = (b_ext == '0);
      ovf      = signed_i && (a_ext == (word_act ? MIN_WORD : MIN_FULL)) && (b_ext == '1);
      shortcut = div_zero | ovf | early;
      short_q  = div_zero ? '1 : (ovf ? a_ext : '0);
      short_r  = (div_zero | early) ? (word_act ? sext32(a_ext) : a_ext) : '0;
   end

`ifdef YSYX_22040210_DIV_EARLY_OUT_EN
   assign early = (a_mag < b_mag);
`else
   assign early = 1'b0;
`endif

   logic [WIDTH:0]   rem_sh, diff;
   logic             ge;
   logic [WIDTH-1:0] rem_nx, quo_nx, q_sgn, r_sgn, fix_q, fix_r;

   // One restoring step plus the sign/word fixup used on the final iteration.
   always_comb begin
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, dvs_q};
      ge     = ~diff[WIDTH];
      rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], ge};
      q_sgn  = negq_q ? ('0 - quo_nx) : quo_nx;
      r_sgn  = negr_q ? ('0 - rem_nx) : rem_nx;
      fix_q  = word_q ? sext32(q_sgn) : q_sgn;
      fix_r  = word_q ? sext32(r_sgn) : r_sgn;
   end

   // Next-state logic; flush wins over any handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = shortcut ? DONE : CALC;
         CALC:    if (cnt_q == '0) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Datapath: load magnitudes on accept, iterate in CALC, publish results entering DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         negq_q      <= 1'b0;
         negr_q      <= 1'b0;
         word_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               dvs_q  <= b_mag;
               rem_q  <= '0;
               quo_q  <= word_act ? (a_mag << SH) : a_mag;
               cnt_q  <= word_act ? CW'(31) : CW'(WIDTH-1);
               negq_q <= a_neg ^ b_neg;
               negr_q <= a_neg;
               word_q <= word_act;
               if (shortcut) begin
                  quotient_q  <= short_q;
                  remainder_q <= short_r;
               end
            end
            CALC: begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0 && !flush) begin
                  quotient_q  <= fix_q;
                  remainder_q <= fix_r;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22040210_div_iter.sv
// tb/tb_ysyx_22040210_div_iter.sv - directed self-checking bench for ysyx_22040210_div_iter
module tb_ysyx_22040210_div_iter;

   localparam int W = 64;
`ifdef YSYX_22040210_DIV_EARLY_OUT_EN
   localparam int EARLY_LAT   = 1;
   localparam int EARLY_LAT_W = 1;
`else
   localparam int EARLY_LAT   = 65;
   localparam int EARLY_LAT_W = 33;
`endif

   logic         clk = 1'b0;
   logic         rst, flush, in_valid, in_ready, signed_i, word_i;
   logic         out_valid, out_ready, busy_o;
   logic [W-1:0] dividend_i, divisor_i, quotient_o, remainder_o;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] last_q;

   typedef struct {
      string        name;
      logic         s;
      logic         w;
      logic [63:0]  a;
      logic [63:0]  b;
      logic [63:0]  q;
      logic [63:0]  r;
      int           lat;
   } vec_t;

   ysyx_22040210_div_iter #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .signed_i    (signed_i),
      .word_i      (word_i),
      .dividend_i  (dividend_i),
      .divisor_i   (divisor_i),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient_o  (quotient_o),
      .remainder_o (remainder_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Present operands for one accept edge, then scramble them; returns at the cycle-1 negedge.
   task automatic start_op(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b);
      signed_i   = s;
      word_i     = w;
      dividend_i = a;
      divisor_i  = b;
      in_valid   = 1'b1;
      @(negedge clk);
      in_valid   = 1'b0;
      signed_i   = ~s;
      word_i     = ~w;
      dividend_i = 64'hDEAD_BEEF_CAFE_F00D;
      divisor_i  = 64'h0123_4567_89AB_CDEF;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (out_valid !== 1'b1) lat = -1;
   endtask

   task automatic test_reset;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      signed_i = 1'b0; word_i = 1'b0; dividend_i = 64'd100; divisor_i = 64'd7;
      repeat (3) @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset.in_ready: got %b want 0", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset.out_valid: got %b want 0", out_valid); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset.busy: got %b want 0", busy_o); end
      n_checks++; if (quotient_o !== 64'd0) begin n_fail++; $display("FAIL reset.quotient: got %h want 0", quotient_o); end
      n_checks++; if (remainder_o !== 64'd0) begin n_fail++; $display("FAIL reset.remainder: got %h want 0", remainder_o); end
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset.in_ready_after: got %b want 1", in_ready); end
   endtask

   task automatic test_divide;
      vec_t v[$];
      int   lat;
      v.push_back('{"u100/7",    1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65});
      v.push_back('{"s-7/2",     1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65});
      v.push_back('{"s7/-2",     1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65});
      v.push_back('{"s-100/-7",  1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 65});
      v.push_back('{"ubig",      1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 65});
      v.push_back('{"u5/0",      1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1});
      v.push_back('{"sovf",      1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 1});
      v.push_back('{"u3/10",     1'b0, 1'b0, 64'd3, 64'd10, 64'd0, 64'd3, EARLY_LAT});
      v.push_back('{"wu_ff/1",   1'b0, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33});
      v.push_back('{"wu_f0/1",   1'b0, 1'b1, 64'h0000_0000_F000_0000, 64'd1, 64'hFFFF_FFFF_F000_0000, 64'd0, 33});
      v.push_back('{"ws-7/2",    1'b1, 1'b1, 64'hAAAA_AAAA_FFFF_FFF9, 64'h5555_5555_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33});
      v.push_back('{"wsovf",     1'b1, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0, 1});
      v.push_back('{"wu_div0",   1'b0, 1'b1, 64'h0000_0000_8000_0005, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, 1});
      v.push_back('{"ws-3/10",   1'b1, 1'b1, 64'h0000_0000_FFFF_FFFD, 64'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, EARLY_LAT_W});
      out_ready = 1'b1;
      foreach (v[i]) begin
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s.in_ready_pre: got %b want 1", v[i].name, in_ready); end
         start_op(v[i].s, v[i].w, v[i].a, v[i].b);
         wait_valid(lat);
         n_checks++; if (lat != v[i].lat) begin n_fail++; $display("FAIL %s.latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
         n_checks++; if (quotient_o !== v[i].q) begin n_fail++; $display("FAIL %s.quotient: got %h want %h", v[i].name, quotient_o, v[i].q); end
         n_checks++; if (remainder_o !== v[i].r) begin n_fail++; $display("FAIL %s.remainder: got %h want %h", v[i].name, remainder_o, v[i].r); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s.in_ready_done: got %b want 0", v[i].name, in_ready); end
         @(negedge clk);
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s.out_valid_retired: got %b want 0", v[i].name, out_valid); end
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s.in_ready_retired: got %b want 1", v[i].name, in_ready); end
         last_q = v[i].q;
      end
   endtask

   task automatic test_flush;
      int lat;
      int seen;
      flush = 1'b1; in_valid = 1'b1; signed_i = 1'b0; word_i = 1'b0;
      dividend_i = 64'd8; divisor_i = 64'd2;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush.in_ready_idle: got %b want 0", in_ready); end
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush.blocks_accept: got %b want 0", busy_o); end
      start_op(1'b0, 1'b0, 64'd1000, 64'd3);
      repeat (9) @(negedge clk);
      n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL flush.busy_calc10: got %b want 1", busy_o); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush.busy_after: got %b want 0", busy_o); end
      n_checks++; if (quotient_o !== last_q) begin n_fail++; $display("FAIL flush.quotient_held: got %h want %h", quotient_o, last_q); end
      seen = 0;
      for (int k = 0; k < 70; k++) begin
         if (out_valid === 1'b1) seen++;
         @(negedge clk);
      end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush.no_out_valid: got %0d want 0", seen); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush.in_ready_next: got %b want 1", in_ready); end
      start_op(1'b0, 1'b0, 64'd9, 64'd3);
      wait_valid(lat);
      n_checks++; if (lat != 65) begin n_fail++; $display("FAIL flush.next_latency: got %0d want 65", lat); end
      n_checks++; if (quotient_o !== 64'd3) begin n_fail++; $display("FAIL flush.next_quotient: got %h want 3", quotient_o); end
      n_checks++; if (remainder_o !== 64'd0) begin n_fail++; $display("FAIL flush.next_remainder: got %h want 0", remainder_o); end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      int lat;
      out_ready = 1'b0;
      start_op(1'b0, 1'b0, 64'd50, 64'd6);
      wait_valid(lat);
      n_checks++; if (lat != 65) begin n_fail++; $display("FAIL bp.latency: got %0d want 65", lat); end
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; signed_i = 1'b0; word_i = 1'b0; dividend_i = 64'd1; divisor_i = 64'd1;
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp.hold_valid[%0d]: got %b want 1", k, out_valid); end
         n_checks++; if (quotient_o !== 64'd8) begin n_fail++; $display("FAIL bp.hold_q[%0d]: got %h want 8", k, quotient_o); end
         n_checks++; if (remainder_o !== 64'd2) begin n_fail++; $display("FAIL bp.hold_r[%0d]: got %h want 2", k, remainder_o); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp.hold_in_ready[%0d]: got %b want 0", k, in_ready); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp.valid_before_retire: got %b want 1", out_valid); end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp.valid_after_retire: got %b want 0", out_valid); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL bp.no_accept_on_retire: got %b want 0", busy_o); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp.in_ready_after: got %b want 1", in_ready); end
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int seen;
      start_op(1'b0, 1'b0, 64'd100, 64'd7);
      repeat (4) @(negedge clk);
      rst = 1'b1; flush = 1'b1;
      @(negedge clk);
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid.busy: got %b want 0", busy_o); end
      n_checks++; if (quotient_o !== 64'd0) begin n_fail++; $display("FAIL rstmid.quotient: got %h want 0", quotient_o); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid.in_ready: got %b want 0", in_ready); end
      rst = 1'b0; flush = 1'b0;
      seen = 0;
      for (int k = 0; k < 70; k++) begin
         if (out_valid === 1'b1) seen++;
         @(negedge clk);
      end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstmid.no_out_valid: got %0d want 0", seen); end
   endtask

   initial begin
      last_q = '0;
      test_reset;
      test_divide;
      test_flush;
      test_backpressure;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_22040210_div_iter.md
YSYX_22040210_DIV_ITER -- requirements
Module: ysyx_22040210_div_iter

Interface
REQ-001 SHALL have parameter: WIDTH, 64, operand/result width in bits (even, >=8).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: flush  input  1  abort in-flight operation.
REQ-005 SHALL have port: in_valid  input  1  operands valid.
REQ-006 SHALL have port: in_ready  output  1  divider can accept operands.
REQ-007 SHALL have port: signed_i  input  1  1 = two's-complement operation, 0 = unsigned.
REQ-008 SHALL have port: word_i  input  1  1 = 32-bit operation on low halves; honoured only when WIDTH==64, otherwise ignored.
REQ-009 SHALL have port: dividend_i  input  WIDTH  dividend.
REQ-010 SHALL have port: divisor_i  input  WIDTH  divisor.
REQ-011 SHALL have port: out_valid  output  1  result valid.
REQ-012 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port: quotient_o  output  WIDTH  quotient.
REQ-014 SHALL have port: remainder_o  output  WIDTH  remainder.
REQ-015 SHALL have port: busy_o  output  1  state != IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE; accept = in_valid & in_ready.
REQ-017 SHALL drive in_ready = (state==IDLE) & ~flush & ~rst, combinationally; operands registered on accept, later input changes ignored.
REQ-018 SHALL use iteration count N = 32 when word mode is active, else WIDTH; operation width is 32 or WIDTH accordingly.
REQ-019 SHALL, in word mode, take the low 32 bits of each operand, sign-extended if signed_i else zero-extended.
REQ-020 SHALL, for signed ops, divide magnitudes; quotient negative iff operand signs differ; remainder sign = dividend sign.
REQ-021 SHALL, for normal ops, go IDLE->CALC on accept, retire one restoring quotient bit per cycle for N cycles, apply sign fixup on the last CALC cycle, enter DONE: out_valid first high N+1 cycles after the accept edge.
REQ-022 SHALL, for divisor==0, go IDLE->DONE directly with quotient all ones and remainder = dividend (out_valid 1 cycle after accept).
REQ-023 SHALL, for signed overflow (dividend = most-negative, divisor = -1), go IDLE->DONE directly with quotient = dividend and remainder = 0.
REQ-024 SHALL, in word mode, sign-extend both results from bit 31 to WIDTH, including unsigned ops.
REQ-025 SHALL hold out_valid, quotient_o and remainder_o stable in DONE until out_ready; on out_valid & out_ready go DONE->IDLE, deasserting out_valid next cycle.
REQ-026 SHALL not accept new operands in the same cycle a result retires; in_ready rises the cycle after.
REQ-027 SHALL, on flush in any state, go to IDLE next cycle with out_valid low and the in-flight result discarded; flush overrides a simultaneous accept or out handshake.
REQ-028 SHALL keep quotient_o and remainder_o at their last values outside DONE.

Reset
REQ-029 SHALL, while rst high, force state IDLE, out_valid 0, quotient_o 0, remainder_o 0, busy_o 0, in_ready 0; rst mid-operation discards the operation and overrides flush.
REQ-030 SHALL accept operands on the first cycle after rst deasserts.

Configuration
REQ-031 SHALL, with YSYX_22040210_DIV_EARLY_OUT_EN defined, also go IDLE->DONE directly when |dividend| < |divisor| (after word/sign handling), giving quotient 0 and remainder = dividend (word results sign-extended).
REQ-032 SHALL, without YSYX_22040210_DIV_EARLY_OUT_EN, take that case through the full N-cycle CALC path with identical results.

Verification
REQ-033 SHALL cover: unsigned 100/7, WIDTH=64, out_ready=1 -> q=14, r=2, out_valid 65 cycles after accept.
REQ-034 SHALL cover: signed -7/2 -> q=-3 (0xFFFF_FFFF_FFFF_FFFD), r=-1; signed 7/-2 -> q=-3, r=1.
REQ-035 SHALL cover: 5/0 -> q=0xFFFF_FFFF_FFFF_FFFF, r=5, out_valid 1 cycle after accept; signed 0x8000_0000_0000_0000/-1 -> q=0x8000_0000_0000_0000, r=0.
REQ-036 SHALL cover: word unsigned 0xFFFF_FFFF/1 -> q=0xFFFF_FFFF_FFFF_FFFF, r=0, out_valid 33 cycles after accept.
REQ-037 SHALL cover: flush at CALC cycle 10 -> no out_valid, busy_o low next cycle, next op 9/3 -> q=3, r=0.
REQ-038 SHALL cover: out_ready low 5 cycles in DONE -> outputs stable and in_ready low; retire -> in_ready high the following cycle.
